// File: rtl/checker_pkg.sv
// Shared types and sizing helpers for the truth-table checker and its minterm sweeper.
`timescale 1ns/1ps
package checker_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

  localparam int N_IN_DEFAULT = 2;
  localparam int NUM_MT       = 2 ** N_IN_DEFAULT;

  // One extra bit so a count of every minterm still fits.
  function automatic int mt_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/minterm_sweeper.sv
// Minterm index counter (clear/increment/last) and the settle down-counter used between drive and sample.
`timescale 1ns/1ps
module minterm_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic            dec_i,
  output logic [N_IN-1:0] idx_o,
  output logic            last_o,
  output logic            settle_zero_o
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

  logic [N_IN-1:0] idx_q, idx_d;
  logic [SW-1:0]   settle_q, settle_d;

  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + N_IN'(1);
    end
    // Loaded with SETTLE-1 so WAIT lasts exactly SETTLE cycles including the zero cycle.
    if (load_i) begin
      settle_d = SETTLE_LOAD;
    end else if (dec_i && (settle_q != '0)) begin
      settle_d = settle_q - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  assign idx_o         = idx_q;
  assign last_o        = &idx_q;
  assign settle_zero_o = (settle_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input minterms into a combinational DUT and checks s/t against an expected truth table and each other.
`timescale 1ns/1ps
module truth_table_checker
  import checker_pkg::*;
#(
  parameter int                 N_IN   = N_IN_DEFAULT,
  parameter logic [2**N_IN-1:0] EXPECT = NUM_MT'(4'b1000),
  parameter int                 SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_s,
  input  logic                      dut_t,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [mt_width(N_IN)-1:0] err_count,
  output logic                      equiv_fail,
  output logic [N_IN-1:0]           first_err_idx,
  output logic                      first_err_vld
);

  localparam int EW = mt_width(N_IN);

  state_t          state_q, state_d;
  logic            s_q, t_q;
  logic [EW-1:0]   errCnt_q, errCnt_d;
  logic            equiv_q, equiv_d;
  logic [N_IN-1:0] firstIdx_q, firstIdx_d;
  logic            firstVld_q, firstVld_d;
  logic            busy_q, done_q, pass_q;

  logic            clr, inc, load, dec;
  logic [N_IN-1:0] idx;
  logic            last, settleZero;
  logic            expBit, mismatch;

  minterm_sweeper #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_sweeper (
    .clk           (clk),
    .reset_n       (reset_n),
    .clr_i         (clr),
    .inc_i         (inc),
    .load_i        (load),
    .dec_i         (dec),
    .idx_o         (idx),
    .last_o        (last),
    .settle_zero_o (settleZero)
  );

  assign expBit   = EXPECT[idx];
  assign mismatch = (s_q != expBit) || (t_q != expBit);

  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    inc        = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    errCnt_d   = errCnt_q;
    equiv_d    = equiv_q;
    firstIdx_d = firstIdx_q;
    firstVld_d = firstVld_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr        = 1'b1;
          errCnt_d   = '0;
          equiv_d    = 1'b0;
          firstIdx_d = '0;
          firstVld_d = 1'b0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (SETTLE == 0) begin
          state_d = SAMPLE;
        end else begin
          load    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (settleZero) begin
          state_d = SAMPLE;
        end else begin
          dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          errCnt_d = errCnt_q + EW'(1);
          if (!firstVld_q) begin
            firstIdx_d = idx;
            firstVld_d = 1'b1;
          end
        end
        if (s_q != t_q) begin
          equiv_d = 1'b1;
        end
        if (last) begin
          state_d = DONE;
        end else begin
          inc     = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the current state, so done rises one edge after DONE is entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      s_q        <= 1'b0;
      t_q        <= 1'b0;
      errCnt_q   <= '0;
      equiv_q    <= 1'b0;
      firstIdx_q <= '0;
      firstVld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= dut_s;
      t_q        <= dut_t;
      errCnt_q   <= errCnt_d;
      equiv_q    <= equiv_d;
      firstIdx_q <= firstIdx_d;
      firstVld_q <= firstVld_d;
      busy_q     <= (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
      done_q     <= (state_q == DONE);
      pass_q     <= (state_q == DONE) && (errCnt_q == '0) && !equiv_q;
    end
  end

  assign dut_in        = idx;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = errCnt_q;
  assign equiv_fail    = equiv_q;
  assign first_err_idx = firstIdx_q;
  assign first_err_vld = firstVld_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: four checker instances (default, SETTLE=0, SETTLE=3, N_IN=1) driven by small behavioural gates.
`timescale 1ns/1ps
module tb_truth_table_checker;

  logic clk;
  logic reset_n;
  logic start;
  int   mode;

  logic [1:0] in0;
  logic       s0, t0, busy0, done0, pass0, eq0, vld0;
  logic [2:0] err0;
  logic [1:0] fidx0;

  logic [1:0] inZ;
  logic       sZ, busyZ, doneZ, passZ, eqZ, vldZ;
  logic [2:0] errZ;
  logic [1:0] fidxZ;

  logic [1:0] inL;
  logic       sL, busyL, doneL, passL, eqL, vldL;
  logic [2:0] errL;
  logic [1:0] fidxL;

  logic [0:0] inN;
  logic       sN, busyN, doneN, passN, eqN, vldN;
  logic [1:0] errN;
  logic [0:0] fidxN;

  int checks;
  int errors;

  int doneE0, doneEZ, doneEL, doneEN;
  int dutInAt [0:40];
  int errAtStart;
  bit overlap, passBad, rstOr;

  truth_table_checker u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_in(in0), .dut_s(s0), .dut_t(t0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .equiv_fail(eq0),
    .first_err_idx(fidx0), .first_err_vld(vld0)
  );

  truth_table_checker #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(0)) uZ (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_in(inZ), .dut_s(sZ), .dut_t(sZ),
    .busy(busyZ), .done(doneZ), .pass(passZ), .err_count(errZ), .equiv_fail(eqZ),
    .first_err_idx(fidxZ), .first_err_vld(vldZ)
  );

  truth_table_checker #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(3)) uL (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_in(inL), .dut_s(sL), .dut_t(sL),
    .busy(busyL), .done(doneL), .pass(passL), .err_count(errL), .equiv_fail(eqL),
    .first_err_idx(fidxL), .first_err_vld(vldL)
  );

  truth_table_checker #(.N_IN(1), .EXPECT(2'b10), .SETTLE(1)) uN (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_in(inN), .dut_s(sN), .dut_t(sN),
    .busy(busyN), .done(doneN), .pass(passN), .err_count(errN), .equiv_fail(eqN),
    .first_err_idx(fidxN), .first_err_vld(vldN)
  );

  // mode 0: s=t=AND, mode 1: s=t=OR, mode 2: s=AND with t stuck at 0
  always_comb begin
    s0 = (mode == 1) ? (in0[1] | in0[0]) : (in0[1] & in0[0]);
    t0 = (mode == 2) ? 1'b0 : s0;
    sZ = inZ[1] & inZ[0];
    sL = inL[1] & inL[0];
    sN = inN[0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start pulse at edge 0, then 40 edges; optional extra start pulses and a one-edge reset.
  task automatic applyStimulus(input int pulseA, input int pulseB, input int rstEdge);
    doneE0 = -1; doneEZ = -1; doneEL = -1; doneEN = -1;
    overlap = 1'b0; passBad = 1'b0; rstOr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dutInAt[0] = int'(in0);
    errAtStart = int'(err0);
    for (int e = 1; e <= 40; e++) begin
      start   = (e == pulseA || e == pulseB) ? 1'b1 : 1'b0;
      reset_n = (e == rstEdge) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      dutInAt[e] = int'(in0);
      if (done0 && doneE0 < 0) doneE0 = e;
      if (doneZ && doneEZ < 0) doneEZ = e;
      if (doneL && doneEL < 0) doneEL = e;
      if (doneN && doneEN < 0) doneEN = e;
      if (busy0 && done0) overlap = 1'b1;
      if (pass0 && !done0) passBad = 1'b1;
      if (e == rstEdge)
        rstOr = |{in0, busy0, done0, pass0, err0, eq0, fidx0, vld0};
    end
    start   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mode    = 0;
    start   = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dut_in", int'(in0), 0);
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_done", int'(done0), 0);
    checkOutput("reset_pass", int'(pass0), 0);
    checkOutput("reset_err_count", int'(err0), 0);
    checkOutput("reset_first_vld", int'(vld0), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Test 1 + 6: AND gate, all settle variants and the 1-input boundary
    mode = 0;
    applyStimulus(0, 0, 0);
    checkOutput("t1_dut_in_e0", dutInAt[0], 0);
    checkOutput("t1_dut_in_e3", dutInAt[3], 1);
    checkOutput("t1_dut_in_e6", dutInAt[6], 2);
    checkOutput("t1_dut_in_e9", dutInAt[9], 3);
    checkOutput("t1_dut_in_done", int'(in0), 3);
    checkOutput("t1_done_edge", doneE0, 13);
    checkOutput("t1_pass", int'(pass0), 1);
    checkOutput("t1_err_count", int'(err0), 0);
    checkOutput("t1_first_vld", int'(vld0), 0);
    checkOutput("t1_first_idx", int'(fidx0), 0);
    checkOutput("t1_busy_done_overlap", int'(overlap), 0);
    checkOutput("t1_pass_without_done", int'(passBad), 0);
    checkOutput("t1_busy_end", int'(busy0), 0);
    checkOutput("t6_settle0_done_edge", doneEZ, 9);
    checkOutput("t6_settle0_pass", int'(passZ), 1);
    checkOutput("t6_settle3_done_edge", doneEL, 21);
    checkOutput("t6_settle3_pass", int'(passL), 1);
    checkOutput("nin1_done_edge", doneEN, 7);
    checkOutput("nin1_pass", int'(passN), 1);
    checkOutput("nin1_dut_in_done", int'(inN), 1);

    // Test 2: OR gate against AND table
    mode = 1;
    applyStimulus(0, 0, 0);
    checkOutput("t2_done_edge", doneE0, 13);
    checkOutput("t2_err_count", int'(err0), 2);
    checkOutput("t2_first_idx", int'(fidx0), 1);
    checkOutput("t2_first_vld", int'(vld0), 1);
    checkOutput("t2_equiv_fail", int'(eq0), 0);
    checkOutput("t2_pass", int'(pass0), 0);

    // Test 3: t stuck at 0
    mode = 2;
    applyStimulus(0, 0, 0);
    checkOutput("t3_equiv_fail", int'(eq0), 1);
    checkOutput("t3_err_count", int'(err0), 1);
    checkOutput("t3_first_idx", int'(fidx0), 3);
    checkOutput("t3_first_vld", int'(vld0), 1);
    checkOutput("t3_pass", int'(pass0), 0);

    // Test 4: reset during WAIT of minterm 2 aborts, then a clean run
    mode = 0;
    applyStimulus(0, 0, 8);
    checkOutput("t4_outputs_after_reset", int'(rstOr), 0);
    checkOutput("t4_no_done_after_abort", doneE0, -1);
    checkOutput("t4_idle_dut_in", int'(in0), 0);
    applyStimulus(0, 0, 0);
    checkOutput("t4_rerun_done_edge", doneE0, 13);
    checkOutput("t4_rerun_pass", int'(pass0), 1);
    checkOutput("t4_rerun_err_count", int'(err0), 0);

    // Test 5: starts while busy are ignored; start in DONE clears and reruns
    mode = 1;
    applyStimulus(3, 7, 0);
    checkOutput("t5_done_edge_with_pulses", doneE0, 13);
    checkOutput("t5_err_count", int'(err0), 2);
    checkOutput("t5_overlap", int'(overlap), 0);
    mode = 0;
    applyStimulus(0, 0, 0);
    checkOutput("t5_err_cleared_on_start", errAtStart, 0);
    checkOutput("t5_restart_done_edge", doneE0, 13);
    checkOutput("t5_restart_pass", int'(pass0), 1);
    checkOutput("t5_restart_first_vld", int'(vld0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
